// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
// The master side (control logic) issues operands; the slave side (subtractor) returns results.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output a,
        output b,
        output bin,
        input  diff,
        input  bout,
        input  overflow,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  bin,
        output diff,
        output bout,
        output overflow,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin: one registered full-subtractor cell, one difference bit per clock,
// LSB first, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_subtractor_if.slave   bus
);

    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    if (WIDTH < 2) begin : gen_width_check
        $error("serial_subtractor: WIDTH must be at least 2");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bit_d;
    logic bit_nb;
    logic last_bit;

    // Full-subtractor cell on the current LSBs of the shift registers.
    always_comb begin
        bit_d    = a_q[0] ^ b_q[0] ^ borrow_q;
        bit_nb   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d  = StShift;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
                    bout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end

            StShift: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                diff_d   = {bit_d, diff_q[WIDTH-1:1]};
                borrow_d = bit_nb;
                if (last_bit) begin
                    // Counter holds at WIDTH-1 so it never wraps within an operation.
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bout_d  = bit_nb;
                    ovf_d   = (a_msb_q != b_msb_q) & (bit_d != a_msb_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.diff     = diff_q;
    assign bus.bout     = bout_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results computed with plain
// integer arithmetic; a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy_run = 0;
    exp_t scb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned and signed integer arithmetic on the operands.
    function automatic exp_t model(input int a, input int b, input int bi);
        exp_t e;
        int   r, sa, sb, sr;
        r      = a - b - bi;
        e.diff = W'(r);
        e.bout = (a < b + bi);
        sa     = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
        sb     = (b >= 2 ** (W - 1)) ? b - 2 ** W : b;
        sr     = sa - sb - bi;
        e.ovf  = (sr < -(2 ** (W - 1))) || (sr > 2 ** (W - 1) - 1);
        e.acc  = 0;
        return e;
    endfunction

    task automatic check_zero(input string name);
        chk({name, "_diff"}, int'(bus.diff), 0);
        chk({name, "_flags"}, int'({bus.bout, bus.overflow, bus.busy, bus.done}), 0);
    endtask

    // Issue one operation to an idle DUT; returns at the negedge after the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bi;
        @(posedge clk);
        @(negedge clk);
        e     = model(int'(a), int'(b), int'(bi));
        e.acc = cyc;
        scb.push_back(e);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((scb.size() != 0 || bus.busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout: %0d results still outstanding after 200 cycles", scb.size());
            scb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: diff=0x%0h with no outstanding operation", bus.diff);
            end else begin
                exp_t e;
                e = scb.pop_front();
                chk("diff", int'(bus.diff), int'(e.diff));
                chk("bout", int'(bus.bout), int'(e.bout));
                chk("overflow", int'(bus.overflow), int'(e.ovf));
                chk("latency", cyc - e.acc, W);
                chk("busy_cycles", busy_run, W);
                chk("busy_at_done", int'(bus.busy), 0);
            end
            busy_run = 0;
        end else if (bus.busy === 1'b1) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst       = 1'b0;
        #1 rst    = 1'b1;
        #1 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Directed cases.
        run_op(8'd100, 8'd37, 1'b0);  wait_idle();
        run_op(8'h05, 8'h0A, 1'b0);   wait_idle();
        run_op(8'h00, 8'h00, 1'b1);   wait_idle();
        run_op(8'h80, 8'h01, 1'b0);   wait_idle();
        run_op(8'h7F, 8'hFF, 1'b0);   wait_idle();
        run_op(8'h80, 8'h7F, 1'b1);   wait_idle();

        // Start while busy is ignored and operands are not re-sampled.
        run_op(8'h10, 8'h01, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.bin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-operation discards it without a done pulse.
        run_op(8'h55, 8'h22, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        scb.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("after_rst");
        run_op(8'h20, 8'h10, 1'b0);   wait_idle();

        // Start held high: accepted again from the done cycle, back to back.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h09;
        bus.b     = 8'h03;
        bus.bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        e     = model(9, 3, 0);
        e.acc = cyc;
        scb.push_back(e);
        bus.a = 8'h03;
        bus.b = 8'h09;
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        e     = model(3, 9, 0);
        e.acc = cyc;
        scb.push_back(e);
        bus.start = 1'b0;
        wait_idle();

        // Randomized operands.
        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom_range(0, 2 ** W - 1)), W'($urandom_range(0, 2 ** W - 1)),
                   1'($urandom_range(0, 1)));
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
